// File: rtl/generic_fifo_pkg.sv
// Shared constants for the generic FIFO family: default data width and
// the legal range of the read-side output buffer depth.
package generic_fifo_pkg;

  localparam int DAT_WIDTH_DEF    = 35;
  localparam int OBUF_ENTRIES_MIN = 2;
  localparam int OBUF_ENTRIES_MAX = 4;
  localparam int OBUF_USED_W      = 3;

endpackage

// File: rtl/generic_sc_obuf.sv
// Single-clock circular output buffer: storage, head/tail pointers and an
// occupancy count, driven by push, pop and clear strobes.
module generic_sc_obuf
  import generic_fifo_pkg::*;
#(
  parameter int DAT_WIDTH = DAT_WIDTH_DEF,
  parameter int ENTRIES   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DAT_WIDTH-1:0]   push_data,
  output logic [DAT_WIDTH-1:0]   head_data,
  output logic [OBUF_USED_W-1:0] used
);

  localparam int PTR_W = $clog2(ENTRIES);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(ENTRIES - 1);

  logic [DAT_WIDTH-1:0]   mem_r [ENTRIES];
  logic [PTR_W-1:0]       head_r;
  logic [PTR_W-1:0]       tail_r;
  logic [OBUF_USED_W-1:0] used_r;

  // Depth need not be a power of two, so wrap explicitly at the last entry.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    ptr_inc = (ptr == PTR_LAST) ? {PTR_W{1'b0}} : ptr + PTR_W'(1);
  endfunction

  // Pointer and occupancy update; clear has priority over push/pop.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      head_r <= {PTR_W{1'b0}};
      tail_r <= {PTR_W{1'b0}};
      used_r <= {OBUF_USED_W{1'b0}};
    end else begin
      if (push) begin
        tail_r <= ptr_inc(tail_r);
      end
      if (pop) begin
        head_r <= ptr_inc(head_r);
      end
      case ({push, pop})
        2'b10:   used_r <= used_r + OBUF_USED_W'(1);
        2'b01:   used_r <= used_r - OBUF_USED_W'(1);
        default: used_r <= used_r;
      endcase
    end
  end

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push && !clear && !reset) begin
      mem_r[tail_r] <= push_data;
    end
  end

  assign head_data = mem_r[head_r];
  assign used      = used_r;

endmodule

// File: rtl/generic_2clk_fifo_rd_prefetch.sv
// Read-side prefetch stage: pulls words from the FIFO RAM (one-cycle read
// latency) into a small output buffer presented as a valid/ready stream.
module generic_2clk_fifo_rd_prefetch
  import generic_fifo_pkg::*;
#(
  parameter int DAT_WIDTH    = DAT_WIDTH_DEF,
  parameter int OBUF_ENTRIES = 2
) (
  input  logic                 rd_clk,
  input  logic                 rd_reset,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_op,
  input  logic [DAT_WIDTH-1:0] fifo_rd_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DAT_WIDTH-1:0] out_data,
  output logic [2:0]           obuf_used,
  output logic [15:0]          pop_cnt,
  output logic                 underrun_err
);

  localparam int ENTRIES_C = (OBUF_ENTRIES < OBUF_ENTRIES_MIN) ? OBUF_ENTRIES_MIN :
                             (OBUF_ENTRIES > OBUF_ENTRIES_MAX) ? OBUF_ENTRIES_MAX :
                             OBUF_ENTRIES;

  logic                   inflight_r;
  logic [15:0]            pop_cnt_r;
  logic                   underrun_r;
  logic                   rd_op_s;
  logic                   push_s;
  logic                   xfer_s;
  logic [OBUF_USED_W-1:0] used_s;
  logic [3:0]             occupancy_s;

  // Count the in-flight word as occupied so a returning word always has room.
  assign occupancy_s = {1'b0, used_s} + {3'b000, inflight_r};
  assign rd_op_s     = !rd_reset && !fifo_empty && !flush &&
                       (occupancy_s < 4'(ENTRIES_C));
  assign push_s      = inflight_r && !flush;
  assign out_valid   = !rd_reset && (used_s != {OBUF_USED_W{1'b0}});
  assign xfer_s      = out_valid && out_ready && !flush;

  generic_sc_obuf #(
    .DAT_WIDTH (DAT_WIDTH),
    .ENTRIES   (ENTRIES_C)
  ) u_obuf (
    .clk       (rd_clk),
    .reset     (rd_reset),
    .clear     (flush),
    .push      (push_s),
    .pop       (xfer_s),
    .push_data (fifo_rd_data),
    .head_data (out_data),
    .used      (used_s)
  );

  // In-flight tracking, delivered-word counter and sticky underrun flag.
  always_ff @(posedge rd_clk) begin
    if (rd_reset) begin
      inflight_r <= 1'b0;
      pop_cnt_r  <= 16'd0;
      underrun_r <= 1'b0;
    end else begin
      inflight_r <= rd_op_s && !flush;
      if (xfer_s) begin
        pop_cnt_r <= pop_cnt_r + 16'd1;
      end
      if (rd_op_s && fifo_empty) begin
        underrun_r <= 1'b1;
      end
    end
  end

  assign fifo_rd_op   = rd_op_s;
  assign obuf_used    = used_s;
  assign pop_cnt      = pop_cnt_r;
  assign underrun_err = underrun_r;

endmodule

// File: tb/tb_generic_2clk_fifo_rd_prefetch.sv
// Bench for the read prefetch stage: a queue-based model of buffer contents
// and RAM read latency is compared against the design every cycle.
module tb_generic_2clk_fifo_rd_prefetch;

  localparam int DW = 35;
  localparam int NE = 3;

  logic          rd_clk = 1'b0;
  logic          rd_reset;
  logic          fifo_empty;
  logic          fifo_rd_op;
  logic [DW-1:0] fifo_rd_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [2:0]    obuf_used;
  logic [15:0]   pop_cnt;
  logic          underrun_err;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            rd_pulses;

  logic [DW-1:0] q_m [$];
  logic          infl_m  = 1'b0;
  logic [DW-1:0] pend_m  = '0;
  logic [15:0]   cnt_m   = 16'd0;
  logic          und_m   = 1'b0;

  generic_2clk_fifo_rd_prefetch #(
    .DAT_WIDTH    (DW),
    .OBUF_ENTRIES (NE)
  ) dut (
    .rd_clk       (rd_clk),
    .rd_reset     (rd_reset),
    .fifo_empty   (fifo_empty),
    .fifo_rd_op   (fifo_rd_op),
    .fifo_rd_data (fifo_rd_data),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .obuf_used    (obuf_used),
    .pop_cnt      (pop_cnt),
    .underrun_err (underrun_err)
  );

  always #5 rd_clk = ~rd_clk;

  function automatic logic [DW-1:0] rand_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: entered at posedge+1 with inputs set; checks at the falling
  // edge, advances the model across the next rising edge.
  task automatic step(input bit forced);
    logic exp_rd_op;
    logic exp_valid;
    fifo_rd_data = infl_m ? pend_m : rand_word();
    #4;
    exp_rd_op = forced ? 1'b1 :
                (!rd_reset && !fifo_empty && !flush && ((q_m.size() + int'(infl_m)) < NE));
    exp_valid = !rd_reset && (q_m.size() != 0);
    if (!forced) chk("rd_op", 64'(fifo_rd_op), 64'(exp_rd_op));
    if (fifo_rd_op === 1'b1) rd_pulses++;
    chk("out_valid", 64'(out_valid), 64'(exp_valid));
    if (exp_valid) chk("out_data", 64'(out_data), 64'(q_m[0]));
    chk("obuf_used", 64'(obuf_used), 64'(q_m.size()));
    chk("pop_cnt", 64'(pop_cnt), 64'(cnt_m));
    chk("underrun", 64'(underrun_err), 64'(und_m));
    if (rd_reset) begin
      q_m.delete();
      infl_m = 1'b0;
      cnt_m  = 16'd0;
      und_m  = 1'b0;
    end else if (flush) begin
      q_m.delete();
      infl_m = 1'b0;
    end else begin
      if (exp_valid && out_ready) begin
        void'(q_m.pop_front());
        cnt_m = cnt_m + 16'd1;
      end
      if (infl_m) q_m.push_back(fifo_rd_data);
      if (exp_rd_op && fifo_empty) und_m = 1'b1;
      infl_m = exp_rd_op;
      if (exp_rd_op) pend_m = rand_word();
    end
    @(posedge rd_clk);
    #1;
  endtask

  task automatic do_reset();
    rd_reset   = 1'b1;
    flush      = 1'b0;
    fifo_empty = 1'b1;
    out_ready  = 1'b0;
    step(1'b0);
    step(1'b0);
    rd_reset   = 1'b0;
  endtask

  initial begin
    rd_reset     = 1'b1;
    fifo_empty   = 1'b1;
    flush        = 1'b0;
    out_ready    = 1'b0;
    fifo_rd_data = '0;
    @(posedge rd_clk);
    #1;
    do_reset();

    // Streaming at full rate.
    fifo_empty = 1'b0;
    out_ready  = 1'b1;
    for (int i = 0; i < 102; i++) step(1'b0);
    chk("stream_pop_cnt", 64'(pop_cnt), 64'd100);

    // Consumer stalled: buffer fills, then reads stop.
    do_reset();
    rd_pulses  = 0;
    fifo_empty = 1'b0;
    out_ready  = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b0);
    chk("stall_pulses", 64'(rd_pulses), 64'(NE));
    chk("stall_used", 64'(obuf_used), 64'(NE));

    // Flush with one word buffered and one returning.
    do_reset();
    fifo_empty = 1'b0;
    out_ready  = 1'b0;
    step(1'b0);
    step(1'b0);
    flush = 1'b1;
    step(1'b0);
    flush      = 1'b0;
    fifo_empty = 1'b1;
    step(1'b0);
    chk("flush_used", 64'(obuf_used), 64'd0);
    out_ready = 1'b1;
    step(1'b0);

    // Toggling empty flag, random backpressure, occasional flush.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      fifo_empty = ~fifo_empty;
      out_ready  = 1'($urandom_range(0, 1));
      flush      = ($urandom_range(0, 40) == 0);
      step(1'b0);
    end
    flush = 1'b0;
    chk("random_underrun", 64'(underrun_err), 64'd0);

    // Fault injection: a read strobe while the FIFO is empty.
    fifo_empty = 1'b1;
    out_ready  = 1'b1;
    force dut.rd_op_s = 1'b1;
    step(1'b1);
    release dut.rd_op_s;
    for (int i = 0; i < 4; i++) step(1'b0);
    chk("underrun_sticky", 64'(underrun_err), 64'd1);
    do_reset();
    chk("underrun_cleared", 64'(underrun_err), 64'd0);

    // Counter wrap after 65536 deliveries.
    fifo_empty = 1'b0;
    out_ready  = 1'b1;
    for (int i = 0; i < 65538; i++) step(1'b0);
    chk("pop_cnt_wrap", 64'(pop_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
